apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
APB responder terminating transfers issued by the team's APB master. Holds a DEPTH-word register file and inserts a programmable number of wait states via Pready. Flags illegal accesses with Pslverr. Sits at the far end of the AHB-to-APB bridge, giving the bridge and its UVM environment a cycle-accurate slave model and a synthesizable peripheral.

Parameters:
DSIZE, 32, data width in bits (multiple of 8)
ASIZE, 32, address width in bits
DEPTH, 16, number of DSIZE-bit words (power of two, >=2)

Ports:
Pclk  input  1  clock, all logic on rising edge
Preset  input  1  synchronous reset, active-high
Psel  input  1  slave select from master
Penable  input  1  access phase indicator
Pwrite  input  1  1=write, 0=read
Paddr  input  ASIZE  byte address
Pdata  input  DSIZE  write data
wait_cfg  input  4  wait states per transfer, 0..15, sampled at setup
Prdata  output  DSIZE  read data, valid only while Pready=1
Pready  output  1  transfer completes on edge where Psel&Penable&Pready
Pslverr  output  1  error response, valid only while Pready=1

Behaviour:
- Reset (Preset=1 at rising edge): state=IDLE, Pready=0, Pslverr=0, Prdata=0, wait counter=0, all DEPTH words=0. Reset mid-transfer aborts it and commits no write.
- All outputs are registered; no combinational path from inputs to outputs.
- Address decode: idx = Paddr[log2(DEPTH)+1:2].
- Error condition: Paddr >= 4*DEPTH or Paddr[1:0] != 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Setup detected (Psel=1, Penable=0): latch wait_cfg into counter.
  - wait_cfg==0: go to RESP, set Pready=1 so the first access cycle completes (zero-wait transfer).
  - Otherwise go to WAIT.
  - Psel=1 with Penable=1 but no prior setup: ignored, stay IDLE.
- WAIT:
  - Pready=0; counter decrements each cycle.
  - At counter==1, go to RESP and set Pready=1. Pready is therefore first high in access cycle number wait_cfg+1.
  - Psel=0 during WAIT: abort to IDLE, no write, Pready stays 0.
  - wait_cfg changes during WAIT are ignored.
- RESP (Pready=1, held exactly one cycle):
  - Prdata and Pslverr are loaded on the same edge that raises Pready.
  - Read, no error: Prdata=mem[idx].
  - Read, error: Prdata=0, Pslverr=1.
  - Write, no error: mem[idx]<=Pdata on the completion edge.
  - Write, error: memory unchanged, Pslverr=1, Prdata=0.
  - After the completion edge: Pready=0, Pslverr=0, Prdata=0, state=IDLE.
  - A new setup in the very next cycle is accepted normally (back-to-back transfers supported).
- Read-after-write to the same idx in consecutive transfers returns the new data.
- Pwrite, Paddr and Pdata are sampled at the completion edge. The master holds them stable from setup, so sampling at setup is equivalent.

Test Plan:
- Reset then read Paddr=0x8, wait_cfg=0 -> Pready high in first access cycle, Prdata=0x00000000, Pslverr=0.
- Write 0xDEADBEEF to 0x4, wait_cfg=0, then read 0x4 -> read returns 0xDEADBEEF. Each transfer is exactly 2 cycles (setup+access); back-to-back has no idle gap.
- wait_cfg=3, write 0x12345678 to 0x3C -> Pready low for 3 access cycles, high on the 4th. Reading 0x3C returns 0x12345678.
- Write 0xFFFFFFFF to 0x40, read 0x40, write to 0x5 (all DEPTH=16) -> each completes with Pslverr=1, Prdata=0. Full readback of words 0..15 shows no change.
- wait_cfg=5, write 0xA5A5A5A5 to 0x10; drop Psel after 2 wait cycles -> Pready never asserts, state returns to IDLE. Reading 0x10 returns the prior value.
- Assert Preset for 1 cycle during WAIT of a write to 0x0 (mem[0]=0x11 beforehand) -> Pready=0 next cycle. Reading 0x0 afterwards returns 0x00000000 (reset clears memory).

Source files
------------

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//
// APB responder holding a DEPTH-word register file. Every transfer is stretched
// by a programmable number of wait states (wait_cfg, captured in the setup
// cycle). Misaligned or out-of-range addresses complete with Pslverr.
// All outputs come straight from flops.
//
// Ports:
//   Pclk      - clock, rising edge
//   Preset    - synchronous active-high reset; clears FSM, outputs and memory
//   Psel      - slave select
//   Penable   - access phase indicator
//   Pwrite    - 1 = write, 0 = read
//   Paddr     - byte address (word index taken from bits [log2(DEPTH)+1:2])
//   Pdata     - write data
//   wait_cfg  - wait states per transfer (0..15), sampled in the setup cycle
//   Prdata    - read data, meaningful only while Pready is high
//   Pready    - high for exactly the one cycle in which the transfer completes
//   Pslverr   - error response, meaningful only while Pready is high

module apb_slave_regfile #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 32,
    parameter int DEPTH = 16
) (
    input  logic             Pclk,
    input  logic             Preset,
    input  logic             Psel,
    input  logic             Penable,
    input  logic             Pwrite,
    input  logic [ASIZE-1:0] Paddr,
    input  logic [DSIZE-1:0] Pdata,
    input  logic [3:0]       wait_cfg,
    output logic [DSIZE-1:0] Prdata,
    output logic             Pready,
    output logic             Pslverr
);

    localparam int               IW         = $clog2(DEPTH);
    localparam logic [ASIZE-1:0] ADDR_LIMIT = ASIZE'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       wait_cnt;
    logic [3:0]       wait_cnt_next;
    logic             ready_next;
    logic             slverr_next;
    logic [DSIZE-1:0] rdata_next;
    logic             write_en;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [IW-1:0]    idx;
    logic             addr_err;
    logic [DSIZE-1:0] resp_rdata;

    assign idx      = Paddr[IW+1:2];
    assign addr_err = (Paddr >= ADDR_LIMIT) || (Paddr[1:0] != 2'b00);

    // Read data presented with the response; writes and errors return zero.
    assign resp_rdata = (!Pwrite && !addr_err) ? mem[idx] : '0;

    // Next-state and next-output logic. The response (Pready, Prdata,
    // Pslverr) is computed one cycle early so it can be registered on the
    // same edge that moves the FSM into RESP.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        ready_next    = 1'b0;
        slverr_next   = 1'b0;
        rdata_next    = '0;
        write_en      = 1'b0;

        case (state)
            IDLE: begin
                // An access phase without a preceding setup is ignored.
                if (Psel && !Penable) begin
                    wait_cnt_next = wait_cfg;
                    if (wait_cfg == 4'd0) begin
                        state_next  = RESP;
                        ready_next  = 1'b1;
                        slverr_next = addr_err;
                        rdata_next  = resp_rdata;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!Psel) begin
                    // Master abandoned the transfer: nothing is committed.
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state_next  = RESP;
                        ready_next  = 1'b1;
                        slverr_next = addr_err;
                        rdata_next  = resp_rdata;
                    end
                end
            end

            RESP: begin
                // Completion edge: commit a legal write, then drop the response.
                state_next = IDLE;
                write_en   = Psel && Penable && Pwrite && !addr_err;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, registered outputs and register file storage.
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            Pready   <= 1'b0;
            Pslverr  <= 1'b0;
            Prdata   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            Pready   <= ready_next;
            Pslverr  <= slverr_next;
            Prdata   <= rdata_next;
            if (write_en) begin
                mem[idx] <= Pdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile
//
// Directed bench for apb_slave_regfile (default parameters: 32-bit data and
// address, 16 words). Expected responses are computed from a shadow copy of
// the register file and queued when a transfer is issued, then popped and
// compared when Pready rises. Inputs are driven 1 time unit after the rising
// edge and outputs are sampled on the falling edge.

module tb_apb_slave_regfile;

    logic        Pclk = 1'b0;
    logic        Preset;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pdata;
    logic [3:0]  wait_cfg;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] exp_mem [16];
    int          checks = 0;
    int          errors = 0;

    apb_slave_regfile #(
        .DSIZE(32),
        .ASIZE(32),
        .DEPTH(16)
    ) dut (
        .Pclk    (Pclk),
        .Preset  (Preset),
        .Psel    (Psel),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Paddr   (Paddr),
        .Pdata   (Pdata),
        .wait_cfg(wait_cfg),
        .Prdata  (Prdata),
        .Pready  (Pready),
        .Pslverr (Pslverr)
    );

    always #5 Pclk = ~Pclk;

    // Safety net in case the flow ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to the input-drive point just after the next rising edge.
    task automatic toDrive();
        @(posedge Pclk);
        #1;
    endtask

    // One complete APB transfer. The expected response is queued up front;
    // on return the bus is idle at the drive point, so calls chain
    // back-to-back with no idle cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] ws);
        exp_t e;
        logic err;
        int   cycles;
        err      = (addr >= 32'd64) || (addr[1:0] != 2'b00);
        e.slverr = err;
        e.rdata  = (!wr && !err) ? exp_mem[addr[5:2]] : 32'h0;
        sb.push_back(e);
        if (wr && !err) exp_mem[addr[5:2]] = data;

        Psel     = 1'b1;
        Penable  = 1'b0;
        Pwrite   = wr;
        Paddr    = addr;
        Pdata    = data;
        wait_cfg = ws;
        @(negedge Pclk);
        checkOutput("setup_pready", 32'(Pready), 32'd0);
        toDrive();
        Penable  = 1'b1;
        wait_cfg = ~ws;
        cycles   = 0;
        do begin
            @(negedge Pclk);
            cycles++;
        end while (!Pready && cycles < 20);
        checkOutput("access_cycles", 32'(cycles), 32'(ws) + 32'd1);
        checkOutput("pready", 32'(Pready), 32'd1);
        e = sb.pop_front();
        if (Pready) begin
            checkOutput("prdata", Prdata, e.rdata);
            checkOutput("pslverr", 32'(Pslverr), 32'(e.slverr));
        end
        toDrive();
        Psel    = 1'b0;
        Penable = 1'b0;
    endtask

    initial begin
        Preset   = 1'b1;
        Psel     = 1'b0;
        Penable  = 1'b0;
        Pwrite   = 1'b0;
        Paddr    = '0;
        Pdata    = '0;
        wait_cfg = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;

        // Reset state
        repeat (2) @(posedge Pclk);
        #1;
        Preset = 1'b0;
        @(negedge Pclk);
        checkOutput("reset_pready", 32'(Pready), 32'd0);
        checkOutput("reset_pslverr", 32'(Pslverr), 32'd0);
        checkOutput("reset_prdata", Prdata, 32'd0);
        toDrive();

        // Access phase with no setup is ignored
        Psel    = 1'b1;
        Penable = 1'b1;
        Paddr   = 32'h8;
        repeat (3) begin
            @(negedge Pclk);
            checkOutput("nosetup_pready", 32'(Pready), 32'd0);
        end
        toDrive();
        Psel    = 1'b0;
        Penable = 1'b0;

        // Zero-wait read of a cleared word, then back-to-back write/read
        applyStimulus(1'b0, 32'h8, 32'h0, 4'd0);
        applyStimulus(1'b1, 32'h4, 32'hDEADBEEF, 4'd0);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'd0);

        // Wait states, including the maximum setting
        applyStimulus(1'b1, 32'h3C, 32'h12345678, 4'd3);
        applyStimulus(1'b0, 32'h3C, 32'h0, 4'd2);
        applyStimulus(1'b0, 32'h3C, 32'h0, 4'd15);

        // Error responses, then full readback
        applyStimulus(1'b1, 32'h40, 32'hFFFFFFFF, 4'd0);
        applyStimulus(1'b0, 32'h40, 32'h0, 4'd1);
        applyStimulus(1'b1, 32'h5, 32'hFFFFFFFF, 4'd2);
        applyStimulus(1'b0, 32'h2, 32'h0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 32'(i * 4), 32'h0, 4'(i % 3));
        end

        // Psel dropped mid-WAIT aborts the write
        applyStimulus(1'b1, 32'h10, 32'h0BADF00D, 4'd1);
        Psel     = 1'b1;
        Penable  = 1'b0;
        Pwrite   = 1'b1;
        Paddr    = 32'h10;
        Pdata    = 32'hA5A5A5A5;
        wait_cfg = 4'd5;
        toDrive();
        Penable = 1'b1;
        repeat (2) begin
            @(negedge Pclk);
            checkOutput("abort_wait_pready", 32'(Pready), 32'd0);
        end
        toDrive();
        Psel    = 1'b0;
        Penable = 1'b0;
        repeat (3) begin
            @(negedge Pclk);
            checkOutput("abort_idle_pready", 32'(Pready), 32'd0);
        end
        toDrive();
        applyStimulus(1'b0, 32'h10, 32'h0, 4'd2);

        // Reset during WAIT aborts the write and clears memory
        applyStimulus(1'b1, 32'h0, 32'h00000011, 4'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'd0);
        Psel     = 1'b1;
        Penable  = 1'b0;
        Pwrite   = 1'b1;
        Paddr    = 32'h0;
        Pdata    = 32'h00000022;
        wait_cfg = 4'd4;
        toDrive();
        Penable = 1'b1;
        @(negedge Pclk);
        checkOutput("prereset_pready", 32'(Pready), 32'd0);
        toDrive();
        Preset = 1'b1;
        @(negedge Pclk);
        checkOutput("midreset_pready", 32'(Pready), 32'd0);
        toDrive();
        Preset  = 1'b0;
        Psel    = 1'b0;
        Penable = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
        @(negedge Pclk);
        checkOutput("postreset_pready", 32'(Pready), 32'd0);
        toDrive();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'd0);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'd1);
        applyStimulus(1'b0, 32'h3C, 32'h0, 4'd0);

        // Pready drops after the final completion and the scoreboard drained
        @(negedge Pclk);
        checkOutput("final_pready", 32'(Pready), 32'd0);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
